// File: rtl/common_types_pkg.sv
// Shared bus-side types for the core's AHB-Lite master path.
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    typedef enum logic {
        MASTER_I,
        MASTER_D
    } arb_master_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    // Requester size code 3 is illegal and degrades to a word access.
    function automatic hsize_t map_dsize(input logic [1:0] sz);
        hsize_t r;
        case (sz)
            2'b00:   r = HSIZE_BYTE;
            2'b01:   r = HSIZE_HALF;
            default: r = HSIZE_WORD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_arb_grant_select.sv
// D-priority winner select with a streak counter that forces
// an I grant after MAX_D_STREAK back-to-back D wins.
module ahb_arb_grant_select #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic win_d
);

    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       i_forced;

    always_comb begin
        i_forced = i_req && (streak_q >= MAX_S);
        win_d    = d_req && !i_forced;
        streak_d = streak_q;
        if (arb_en) begin
            if (win_d && i_req) begin
                streak_d = (streak_q >= MAX_S) ? MAX_S : streak_q + 4'd1;
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Serialises I-fetch and D load/store requests onto one AHB-Lite
// master port, one NONSEQ transfer at a time.
module ahb_master_arbiter
    import common_types_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    arb_state_t  state_q,  state_d;
    arb_master_t grant_q,  grant_d;
    htrans_t     htrans_q, htrans_d;
    hsize_t      size_q,   size_d;
    word_t       addr_q,   addr_d;
    word_t       wdata_q,  wdata_d;
    logic        wen_q,    wen_d;

    logic any_req;
    logic arb_en;
    logic win_d;
    logic done;

    assign any_req = i_req | d_req;
    assign arb_en  = (state_q == ARB_IDLE) && any_req;

    ahb_arb_grant_select #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_sel (
        .clk   (clk),
        .rst   (rst),
        .arb_en(arb_en),
        .i_req (i_req),
        .d_req (d_req),
        .win_d (win_d)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        htrans_d = htrans_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = wen_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d  = ARB_ADDR;
                    htrans_d = HTRANS_NONSEQ;
                    if (win_d) begin
                        grant_d = MASTER_D;
                        addr_d  = d_addr;
                        wen_d   = d_wen;
                        size_d  = map_dsize(d_size);
                        wdata_d = d_wdata;
                    end else begin
                        grant_d = MASTER_I;
                        addr_d  = i_addr;
                        wen_d   = 1'b0;
                        size_d  = HSIZE_WORD;
                        wdata_d = '0;
                    end
                end
            end
            ARB_ADDR: begin
                if (hready) begin
                    state_d  = ARB_DATA;
                    htrans_d = HTRANS_IDLE;
                end
            end
            ARB_DATA: begin
                if (hready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= MASTER_D;
            htrans_q <= HTRANS_IDLE;
            size_q   <= HSIZE_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            htrans_q <= htrans_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
        end
    end

    // Completion is the only combinational path: data-phase hready.
    assign done    = (state_q == ARB_DATA) && hready;
    assign i_ready = done && (grant_q == MASTER_I);
    assign d_ready = done && (grant_q == MASTER_D);
    assign i_err   = i_ready && hresp;
    assign d_err   = d_ready && hresp;
    assign i_rdata = hrdata;
    assign d_rdata = hrdata;

    assign haddr  = addr_q;
    assign htrans = htrans_q;
    assign hwrite = wen_q;
    assign hsize  = size_q;
    assign hwdata = wdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed plus randomized bench for ahb_master_arbiter against a
// transaction-level model of the arbitration and bus timing rules.
module tb_ahb_master_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        i_err;
    logic        d_req;
    logic        d_wen;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int tests = 0;
    int fails = 0;
    int streak_m = 0;
    bit exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    ahb_master_arbiter #(.MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_ready(i_ready), .i_err(i_err),
        .d_req(d_req), .d_wen(d_wen), .d_size(d_size),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ready(d_ready), .d_err(d_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_d();
        d_wen   = 1'($urandom_range(0, 1));
        d_size  = 2'($urandom_range(0, 3));
        d_addr  = $urandom;
        d_wdata = $urandom;
    endtask

    task automatic new_i();
        i_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    // One whole transfer: arbitration cycle, aw address waits,
    // dw data waits. Entered 1ns after a clock edge, DUT idle.
    task automatic xfer(input int aw, input int dw, input bit err,
                        input logic [31:0] rd, output bit won_d);
        bit          wd;
        logic [31:0] ea;
        logic [2:0]  es;
        logic        ew;
        logic [31:0] edat;
        wd = d_req && !(i_req && streak_m >= MAXS);
        if (wd && i_req) streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
        else streak_m = 0;
        if (wd) begin
            ea   = d_addr;
            es   = (d_size == 2'd3) ? 3'd2 : {1'b0, d_size};
            ew   = d_wen;
            edat = d_wdata;
        end else begin
            ea   = i_addr;
            es   = 3'd2;
            ew   = 1'b0;
            edat = 32'h0;
        end
        hready = 1'b1;
        hresp  = 1'b0;
        @(negedge clk);
        chk("arb_htrans", 32'(htrans), 32'd0);
        chk("arb_ready", 32'({i_ready, d_ready}), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k <= aw; k++) begin
            hready = (k == aw);
            hresp  = 1'b0;
            @(negedge clk);
            chk("addr_htrans", 32'(htrans), 32'd2);
            chk("addr_haddr", haddr, ea);
            chk("addr_hsize", 32'(hsize), 32'(es));
            chk("addr_hwrite", 32'(hwrite), 32'(ew));
            chk("addr_ready", 32'({i_ready, d_ready}), 32'd0);
            @(posedge clk); #1;
        end
        for (int k = 0; k <= dw; k++) begin
            hready = (k == dw);
            hresp  = err && (k >= dw - 1);
            hrdata = (k == dw) ? rd : $urandom;
            @(negedge clk);
            chk("data_htrans", 32'(htrans), 32'd0);
            if (wd) chk("data_hwdata", hwdata, edat);
            if (k < dw) begin
                chk("wait_ready", 32'({i_ready, d_ready}), 32'd0);
            end else begin
                chk("done_ready", 32'({i_ready, d_ready}),
                    wd ? 32'd1 : 32'd2);
                chk("done_err", 32'(wd ? d_err : i_err), 32'(err));
                chk("done_rdata", wd ? d_rdata : i_rdata, rd);
            end
            @(posedge clk); #1;
        end
        hready = 1'b1;
        hresp  = 1'b0;
        won_d  = wd;
    endtask

    initial begin
        bit w;
        int aw;
        int dw;
        bit er;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wen = 1'b0; d_size = '0;
        d_addr = '0; d_wdata = '0;
        hrdata = '0; hready = 1'b1; hresp = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hwrite", 32'(hwrite), 32'd0);
        chk("rst_hsize", 32'(hsize), 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_ready", 32'({i_ready, d_ready, i_err, d_err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Asynchronous reset during the address phase
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h55; d_size = 2'd2;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_nonseq", 32'(htrans), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("t1_async_htrans", 32'(htrans), 32'd0);
        chk("t1_async_haddr", haddr, 32'd0);
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        streak_m = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("t1_no_ready", 32'({i_ready, d_ready}), 32'd0);
            chk("t1_idle", 32'(htrans), 32'd0);
        end
        @(posedge clk); #1;

        // Single D word read, zero-wait
        d_req = 1'b1; d_wen = 1'b0; d_size = 2'd2; d_addr = 32'h1000;
        xfer(0, 0, 1'b0, 32'hDEADBEEF, w);
        d_req = 1'b0;
        chk("t2_win", 32'(w), 32'd1);

        // D byte write, two data-phase waits
        d_req = 1'b1; d_wen = 1'b1; d_size = 2'd0;
        d_addr = 32'h2003; d_wdata = 32'hAB000000;
        xfer(0, 2, 1'b0, 32'h0, w);
        d_req = 1'b0;

        // Address-phase stall on a D write
        d_req = 1'b1; d_wen = 1'b1; d_size = 2'd3;
        d_addr = 32'h3000; d_wdata = 32'h1234_5678;
        xfer(3, 0, 1'b0, 32'h0, w);
        d_req = 1'b0;

        // Error response on an I fetch, then a clean fetch
        i_req = 1'b1; i_addr = 32'h100;
        xfer(0, 1, 1'b1, 32'hBAD0_BAD0, w);
        chk("t5_win", 32'(w), 32'd0);
        i_addr = 32'h104;
        xfer(0, 0, 1'b0, 32'h0000_0013, w);
        i_req = 1'b0;

        // Both requesters saturated
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_wen = 1'b0; d_size = 2'd1; d_addr = 32'h4002;
        for (int n = 0; n < 10; n++) begin
            xfer(0, 0, 1'b0, $urandom, w);
            chk("t4_seq", 32'(w), 32'(exp_seq[n]));
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk); #1;
        streak_m = 0;

        // Randomized traffic
        new_d(); new_i();
        d_req = 1'b1; i_req = 1'b1;
        for (int n = 0; n < 300; n++) begin
            aw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            er = ($urandom_range(0, 7) == 0);
            if (er && dw == 0) dw = 1;
            xfer(aw, dw, er, $urandom, w);
            if (w) begin
                d_req = 1'($urandom_range(0, 1));
                new_d();
            end else begin
                i_req = 1'($urandom_range(0, 1));
                new_i();
            end
            if (!d_req && !i_req) d_req = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
Shares the core's single AHB-Lite master port between the instruction-fetch requester (I) and the load/store requester (D). Each requester uses a simple req/ready handshake. The block serialises single NONSEQ transfers, with no address/data-phase overlap. D has priority, and a streak counter prevents starvation of I. It sits between the fetch/memory stages and the system bus interconnect.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced to win the next arbitration (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
i_req  in  1  instruction read request; held with i_addr until i_ready
i_addr  in  32  instruction byte address (word-aligned)
i_rdata  out  32  instruction read data; valid when i_ready=1
i_ready  out  1  one-cycle completion pulse for I
i_err  out  1  bus error flag; qualified by i_ready
d_req  in  1  data request; d_* inputs held stable until d_ready
d_wen  in  1  1=write, 0=read
d_size  in  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
d_addr  in  32  data byte address
d_wdata  in  32  write data, lane-positioned by requester
d_rdata  out  32  read data; valid when d_ready=1
d_ready  out  1  one-cycle completion pulse for D
d_err  out  1  bus error flag; qualified by d_ready
haddr  out  32  AHB address
htrans  out  2  AHB transfer type (htrans_t)
hwrite  out  1  AHB write
hsize  out  3  AHB size
hwdata  out  32  AHB write data
hrdata  in  32  AHB read data
hready  in  1  AHB ready
hresp  in  1  AHB response (1=ERROR)

Behaviour:
- States: ARB_IDLE, ARB_ADDR, ARB_DATA.
- Reset (async, any state): state=ARB_IDLE, grant=D, streak=0, latched addr/wdata/size/wen=0. Outputs: htrans=HTRANS_IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, i_ready=d_ready=i_err=d_err=0. Reset mid-transfer abandons the transfer; no ready is issued.
- ARB_IDLE: htrans=IDLE. If any req is asserted, latch the winner's addr/wen/size/wdata and go to ARB_ADDR next cycle. I is always a read of size word (hsize=3'b010).
- Winner selection:
  - D if d_req and not (i_req and streak>=MAX_D_STREAK).
  - Otherwise I if i_req.
- Streak counter:
  - +1 (saturating at MAX_D_STREAK) when D wins while i_req=1.
  - Cleared when I wins, or when i_req=0 at arbitration.
- ARB_ADDR: drive htrans=NONSEQ and haddr/hwrite/hsize from latched values. Stay while hready=0. On hready=1 go to ARB_DATA.
- ARB_DATA:
  - htrans=IDLE; hwdata=latched wdata (held for the whole data phase).
  - On hready=1: assert the granted requester's ready combinationally in that cycle, with rdata=hrdata and err=hresp. Return to ARB_IDLE.
  - On hready=0: wait. The first ERROR cycle (hresp=1, hready=0) is just a wait.
- Ready/err never asserted outside ARB_DATA&hready. rdata outputs pass hrdata through unconditionally; only meaningful under ready.
- Minimum latency: req seen in IDLE cycle N; address phase N+1; ready in N+2 (zero-wait slave). One idle arbitration cycle separates back-to-back transfers (3 cycles/transfer).
- A requester dropping req before ready is a protocol violation. The latched transfer completes regardless.
- Simultaneous i_req and d_req with streak<MAX: D wins; I's req stays pending.
- Size mapping: hsize = {1'b0, d_size}, with 3 mapped to 3'b010. Misaligned addresses are passed through unchanged; alignment checking belongs to the requester.

Decomposition:
- Add to common_types_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_ADDR, ARB_DATA}.
  - arb_master_t enum {MASTER_I, MASTER_D}.
  - hsize_t enum {HSIZE_BYTE=3'b000, HSIZE_HALF=3'b001, HSIZE_WORD=3'b010}.
- Reuse htrans_t and word_t.
- One natural sub-module: ahb_arb_grant_select, a combinational winner plus a registered streak counter. Everything else stays in the top module.

Test Plan:
1. Reset mid ARB_ADDR (htrans=NONSEQ) -> htrans=IDLE and state=IDLE asynchronously; no i_ready/d_ready pulse afterwards.
2. Single D word read from 0x0000_1000, zero-wait slave returning 0xDEADBEEF -> NONSEQ at N+1 with hsize=2, hwrite=0; d_ready=1 and d_rdata=0xDEADBEEF at N+2.
3. D byte write to 0x0000_2003 with data 0xAB000000, slave inserts 2 wait states in data phase -> hsize=0, hwrite=1; hwdata=0xAB000000 held for 3 cycles; d_ready on the third cycle.
4. i_req and d_req held high continuously, MAX_D_STREAK=4 -> grant sequence D,D,D,D,I,D,D,D,D,I...; each transfer takes 3 cycles.
5. Slave ERROR response on I fetch (hresp=1/hready=0, then hresp=1/hready=1) -> i_ready=1 and i_err=1 on the second cycle only; next arbitration proceeds normally.
6. Address-phase stall: hready=0 for 3 cycles in ARB_ADDR with a D write -> haddr/htrans=NONSEQ stable for 4 cycles, then data phase; no ready until data-phase hready.
